wait_ctrl: RTL and testbench

WAIT_CTRL -- requirements
Module: wait_ctrl

---
 rtl/wait_ctrl.sv | 125 ++++++++++++
 tb/tb_wait_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_ctrl.sv
// wait_ctrl: runs the inst/data bus handshakes and derives pipeline enables and stalls from them
module wait_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_inst_valid,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        hazard_stall,
  input  logic        flush,
  output logic        en_if,
  output logic        en_id,
  output logic        en_ex,
  output logic        en_mem,
  output logic        en_wb,
  output logic        bubble_ex
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} st_t;
  st_t ist, ist_n, dst, dst_n;
  logic idisc, idisc_n, ddisc, ddisc_n;
  logic inst_stall, data_stall, advance, flush_all;
  assign inst_stall = (if_req && ist != DONE) || idisc;
  assign data_stall = (mem_req && dst != DONE) || ddisc;
  assign advance = !inst_stall && !data_stall;
  // a flush only forces the pipeline forward when neither bus still has a handshake in flight
  assign flush_all = flush && (ist == IDLE || ist == DONE) && (dst == IDLE || dst == DONE);
  assign en_ex = !rst && (advance || flush_all);
  assign en_mem = en_ex;
  assign en_wb = en_ex;
  assign en_if = !rst && ((advance && !hazard_stall) || flush_all);
  assign en_id = en_if;
  assign bubble_ex = !rst && ((advance && hazard_stall) || flush_all);
  assign inst_req = ist == REQ;
  assign data_req = dst == REQ;
  assign if_inst_valid = ist == DONE && !idisc;
  // inst channel next state; a flushed handshake is completed but its data dropped
  always_comb begin
    ist_n = ist;
    idisc_n = idisc;
    unique case (ist)
      IDLE: ist_n = if_req && !flush ? REQ : IDLE;
      REQ: begin
        idisc_n = idisc || flush;
        ist_n = inst_addr_ok ? WAIT : REQ;
      end
      WAIT: begin
        idisc_n = inst_data_ok ? 1'b0 : idisc || flush;
        ist_n = !inst_data_ok ? WAIT : (idisc || flush) ? IDLE : DONE;
      end
      DONE: ist_n = advance || flush ? IDLE : DONE;
    endcase
  end
  // data channel next state, same protocol as the inst channel
  always_comb begin
    dst_n = dst;
    ddisc_n = ddisc;
    unique case (dst)
      IDLE: dst_n = mem_req && !flush ? REQ : IDLE;
      REQ: begin
        ddisc_n = ddisc || flush;
        dst_n = data_addr_ok ? WAIT : REQ;
      end
      WAIT: begin
        ddisc_n = data_data_ok ? 1'b0 : ddisc || flush;
        dst_n = !data_data_ok ? WAIT : (ddisc || flush) ? IDLE : DONE;
      end
      DONE: dst_n = advance || flush ? IDLE : DONE;
    endcase
  end
  // inst channel state, address latch on issue, instruction capture on accepted data
  always_ff @(posedge clk) begin
    if (rst) begin
      ist <= IDLE;
      idisc <= 1'b0;
      inst_addr <= '0;
      if_inst <= '0;
    end else begin
      ist <= ist_n;
      idisc <= idisc_n;
      if (ist == IDLE && ist_n == REQ) inst_addr <= if_addr;
      if (ist == WAIT && inst_data_ok && !idisc && !flush) if_inst <= inst_rdata;
    end
  end
  // data channel state, request latch on issue, load data capture on accepted data
  always_ff @(posedge clk) begin
    if (rst) begin
      dst <= IDLE;
      ddisc <= 1'b0;
      data_addr <= '0;
      data_wr <= 1'b0;
      data_size <= '0;
      data_wdata <= '0;
      mem_rdata <= '0;
    end else begin
      dst <= dst_n;
      ddisc <= ddisc_n;
      if (dst == IDLE && dst_n == REQ) begin
        data_addr <= mem_addr;
        data_wr <= mem_wr;
        data_size <= mem_size;
        data_wdata <= mem_wdata;
      end
      if (dst == WAIT && data_data_ok && !ddisc && !flush && !data_wr) mem_rdata <= data_rdata;
    end
  end
endmodule

// File: tb/tb_wait_ctrl.sv
// tb_wait_ctrl: bus slave model with scoreboard, vector table and hand-written corner sequences
module tb_wait_ctrl;
  logic clk = 0, rst = 1;
  logic if_req = 0, inst_addr_ok = 0, inst_data_ok = 0, mem_req = 0, mem_wr = 0;
  logic data_addr_ok = 0, data_data_ok = 0, hazard_stall = 0, flush = 0;
  logic [1:0] mem_size = 0;
  logic [31:0] if_addr = 0, inst_rdata = 0, mem_addr = 0, mem_wdata = 0, data_rdata = 0;
  logic [31:0] if_inst, inst_addr, mem_rdata, data_addr, data_wdata;
  logic if_inst_valid, inst_req, data_req, data_wr;
  logic [1:0] data_size;
  logic en_if, en_id, en_ex, en_mem, en_wb, bubble_ex;
  logic [5:0] en6;
  assign en6 = {en_if, en_id, en_ex, en_mem, en_wb, bubble_ex};

  wait_ctrl dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst),
    .if_inst_valid(if_inst_valid), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .hazard_stall(hazard_stall), .flush(flush), .en_if(en_if), .en_id(en_id), .en_ex(en_ex),
    .en_mem(en_mem), .en_wb(en_wb), .bubble_ex(bubble_ex)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // slave configuration and expectations set by the stimulus thread
  int i_alat = 1, i_dlat = 1, d_alat = 1, d_dlat = 1;
  logic [31:0] i_rd = 0, d_rd = 0, e_iaddr = 0, e_daddr = 0, e_dwdata = 0;
  logic e_dwr = 0;
  logic [1:0] e_dsize = 0;
  bit spur_d = 0;
  logic [31:0] iq[$], dq[$];

  // bus slave: drives handshakes 1 time unit after each rising edge, and pops the scoreboard
  int i_cnt = 0, d_cnt = 0, i_reqs = 0, d_reqs = 0;
  bit i_pend = 0, d_pend = 0, d_fired = 0, prev_valid = 0;
  always @(posedge clk) begin
    #1;
    inst_addr_ok = 0;
    inst_data_ok = 0;
    data_addr_ok = 0;
    data_data_ok = 0;
    if (d_fired) begin
      if (dq.size() == 0) chk("mem_rdata_unexpected", 1, 0);
      else chk("mem_rdata", mem_rdata, dq.pop_front());
    end
    d_fired = 0;
    if (if_inst_valid && !prev_valid) begin
      if (iq.size() == 0) chk("if_inst_unexpected", if_inst_valid, 0);
      else chk("if_inst", if_inst, iq.pop_front());
    end
    prev_valid = if_inst_valid;
    if (rst) begin
      i_pend = 0; d_pend = 0; i_cnt = 0; d_cnt = 0;
    end else begin
      if (inst_req) begin
        chk("inst_addr", inst_addr, e_iaddr);
        i_reqs++; i_cnt++;
        if (i_cnt == i_alat) begin inst_addr_ok = 1; i_cnt = 0; i_pend = 1; end
      end else if (i_pend) begin
        i_cnt++;
        if (i_cnt == i_dlat) begin inst_data_ok = 1; inst_rdata = i_rd; i_cnt = 0; i_pend = 0; end
      end
      if (data_req) begin
        chk("data_addr", data_addr, e_daddr);
        chk("data_ctl", {data_wr, data_size, data_wdata}, {e_dwr, e_dsize, e_dwdata});
        d_reqs++; d_cnt++;
        if (d_cnt == d_alat) begin data_addr_ok = 1; d_cnt = 0; d_pend = 1; end
      end else if (d_pend) begin
        d_cnt++;
        if (d_cnt == d_dlat) begin data_data_ok = 1; data_rdata = d_rd; d_cnt = 0; d_pend = 0; d_fired = 1; end
      end
    end
    if (spur_d) begin data_data_ok = 1; data_rdata = 32'h5A5A5A5A; spur_d = 0; end
  end

  typedef struct {
    int kind;
    logic [1:0] size;
    logic [31:0] addr, wdata, rdata;
    int alat, dlat;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    i_reqs = 0; d_reqs = 0;
    if (v.kind == 0) begin
      i_alat = v.alat; i_dlat = v.dlat; i_rd = v.rdata; e_iaddr = v.addr;
      iq.push_back(v.exp);
      if_addr = v.addr; if_req = 1;
    end else begin
      d_alat = v.alat; d_dlat = v.dlat; d_rd = v.rdata; e_daddr = v.addr;
      e_dwr = v.kind == 2; e_dsize = v.size; e_dwdata = v.wdata;
      dq.push_back(v.exp);
      mem_addr = v.addr; mem_wr = v.kind == 2; mem_size = v.size; mem_wdata = v.wdata; mem_req = 1;
    end
    #1;
    n = 0;
    while (!en_ex && n < 60) begin
      n++;
      chk("en_stall", en6, 0);
      @(negedge clk); #1;
    end
    chk("stall_cycles", n, v.alat + v.dlat + 1);
    chk("en_done", en6, 6'b111110);
    chk("req_cycles", v.kind == 0 ? i_reqs : d_reqs, v.alat);
    if (v.kind == 0) chk("if_inst_valid", if_inst_valid, 1);
    @(negedge clk);
    if_req = 0; mem_req = 0; mem_wr = 0;
  endtask

  initial begin
    int n;
    tbl[0] = '{0, 2'd2, 32'hBFC00000, 32'h0, 32'h24080001, 3, 3, 32'h24080001};
    tbl[1] = '{0, 2'd2, 32'hBFC00004, 32'h0, 32'h3C1D8000, 1, 1, 32'h3C1D8000};
    tbl[2] = '{1, 2'd2, 32'h80000010, 32'h0, 32'hDEADBEEF, 1, 2, 32'hDEADBEEF};
    tbl[3] = '{2, 2'd2, 32'h80000020, 32'hA5A5A5A5, 32'h11111111, 2, 1, 32'hDEADBEEF};
    tbl[4] = '{1, 2'd0, 32'h80000003, 32'h0, 32'h000000FF, 2, 4, 32'h000000FF};
    tbl[5] = '{0, 2'd2, 32'hBFC00008, 32'h0, 32'h8C020000, 4, 2, 32'h8C020000};
    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_en", en6, 0);
    chk("rst_reqs", {inst_req, data_req}, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_valid", if_inst_valid, 0);
    chk("rst_bus", {inst_addr, data_addr}, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("idle_en", en6, 6'b111110);
    // single transactions from the table
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);
    chk("store_keeps_rdata", mem_rdata, 32'h000000FF);
    // concurrent fetch and load, load finishes first and waits for the fetch
    @(negedge clk);
    i_reqs = 0; d_reqs = 0;
    e_iaddr = 32'hBFC00010; i_alat = 1; i_dlat = 5; i_rd = 32'h00000013; iq.push_back(32'h00000013);
    e_daddr = 32'h80000010; d_alat = 1; d_dlat = 1; d_rd = 32'hCAFEF00D; dq.push_back(32'hCAFEF00D);
    e_dwr = 0; e_dsize = 2; e_dwdata = 0;
    if_addr = e_iaddr; if_req = 1;
    mem_addr = e_daddr; mem_wr = 0; mem_size = 2; mem_wdata = 0; mem_req = 1;
    @(negedge clk); #1;
    chk("same_cycle_issue", {inst_req, data_req}, 2'b11);
    n = 0;
    while (!en_ex && n < 60) begin
      n++;
      chk("en_stall_both", en6, 0);
      if (n >= 3) chk("load_hold", mem_rdata, 32'hCAFEF00D);
      if (n >= 3) chk("no_reissue", data_req, 0);
      @(negedge clk); #1;
    end
    chk("both_stall_cycles", n, 6);
    chk("both_done_en", en6, 6'b111110);
    @(negedge clk);
    if_req = 0; mem_req = 0;
    // load-use hazard with no bus activity
    @(negedge clk);
    i_reqs = 0;
    hazard_stall = 1;
    #1;
    chk("hazard_en", en6, 6'b001111);
    @(negedge clk);
    hazard_stall = 0;
    #1;
    chk("hazard_no_req", i_reqs, 0);
    // flush with both channels idle
    flush = 1;
    #1;
    chk("flush_idle_en", en6, 6'b111111);
    @(negedge clk);
    flush = 0;
    // flush while fetch still in REQ
    @(negedge clk);
    i_reqs = 0;
    e_iaddr = 32'h80001000; i_alat = 3; i_dlat = 2; i_rd = 32'h12345678;
    if_addr = e_iaddr; if_req = 1;
    @(negedge clk);
    flush = 1;
    #1;
    chk("flush_req_en", en6, 0);
    chk("flush_req_ireq", inst_req, 1);
    @(negedge clk);
    flush = 0; if_req = 0;
    #1;
    n = 0;
    while (!en_ex && n < 60) begin
      n++;
      chk("disc_valid", if_inst_valid, 0);
      @(negedge clk); #1;
    end
    chk("disc_stall_cycles", n, 4);
    chk("disc_req_cycles", i_reqs, 3);
    chk("disc_idle", {inst_req, if_inst_valid}, 0);
    chk("disc_if_inst", if_inst, 32'h00000013);
    // flush coincident with inst data_ok
    @(negedge clk);
    e_iaddr = 32'h80002000; i_alat = 1; i_dlat = 2; i_rd = 32'hDEADDEAD;
    if_addr = e_iaddr; if_req = 1;
    repeat (3) @(negedge clk);
    flush = 1; if_req = 0;
    @(negedge clk);
    flush = 0;
    #1;
    chk("dok_flush_valid", if_inst_valid, 0);
    chk("dok_flush_en", en6, 6'b111110);
    chk("dok_flush_if_inst", if_inst, 32'h00000013);
    // reset during data WAIT, then a late data_ok
    @(negedge clk);
    e_daddr = 32'h80000040; d_alat = 1; d_dlat = 5; d_rd = 32'h77777777;
    e_dwr = 0; e_dsize = 2; e_dwdata = 0;
    mem_addr = e_daddr; mem_wr = 0; mem_size = 2; mem_wdata = 0; mem_req = 1;
    repeat (3) @(negedge clk);
    rst = 1; mem_req = 0;
    #1;
    chk("rst_mid_en", en6, 0);
    @(negedge clk); #1;
    chk("rst2_reqs", {inst_req, data_req}, 0);
    chk("rst2_bus", {data_addr, data_wdata}, 0);
    chk("rst2_ctl", {data_wr, data_size}, 0);
    chk("rst2_rdata", {if_inst, mem_rdata}, 0);
    chk("rst2_valid", if_inst_valid, 0);
    rst = 0; spur_d = 1;
    @(negedge clk); #1;
    chk("spur_en", en6, 6'b111110);
    @(negedge clk); #1;
    chk("spur_idle", data_req, 0);
    chk("spur_rdata", mem_rdata, 0);
    chk("spur_en2", en6, 6'b111110);
    chk("queues_empty", iq.size() + dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
